// File: rtl/rx_frame_pkg.sv
// Shared types and defaults for the receive-side frame assembler.
package rx_frame_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

    localparam int NUM_BYTES_DEF      = 4;
    localparam int TIMEOUT_CYCLES_DEF = 100000;

endpackage

// File: rtl/rx_frame_assembler_if.sv
// Byte-in / frame-out bundle of the assembler; slave is the assembler side.
interface rx_frame_assembler_if import rx_frame_pkg::*; #(
    parameter int NUM_BYTES = NUM_BYTES_DEF
);
    localparam int WORD_W = 8 * NUM_BYTES;

    logic              rx_ready;
    logic [7:0]        rx_data;
    logic [7:0]        cmd_out;
    logic [WORD_W-1:0] word_out;
    logic              frame_valid;
    logic              busy;
    logic              frame_error;

    modport slave (
        input  rx_ready, rx_data,
        output cmd_out, word_out, frame_valid, busy, frame_error
    );

    modport master (
        output rx_ready, rx_data,
        input  cmd_out, word_out, frame_valid, busy, frame_error
    );
endinterface

// File: rtl/rx_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear.
module rx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count_reg;

    assign expired = (count_reg == CW'(TIMEOUT_CYCLES - 1));

    // Holds at the terminal count so a coinciding byte can still be accepted.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CW'(1);
        end
    end
endmodule

// File: rtl/rx_frame_assembler.sv
// Assembles 1 command byte + NUM_BYTES operand bytes (LSB first) into a frame.
// Optional inter-byte timeout abort is built only when RX_TIMEOUT_EN is defined.
module rx_frame_assembler import rx_frame_pkg::*; #(
    parameter int NUM_BYTES      = NUM_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    rx_frame_assembler_if.slave  bus
);
    localparam int WORD_W = 8 * NUM_BYTES;
    localparam int CNT_W  = $clog2(NUM_BYTES) + 1;

    rx_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [7:0]        cmd_stage_reg, cmd_stage_next;
    logic [WORD_W-1:0] stage_reg, stage_next;
    logic [7:0]        cmd_out_reg, cmd_out_next;
    logic [WORD_W-1:0] word_reg, word_next;
    logic              frame_valid_reg, frame_valid_next;
    logic              frame_error_next;
    logic              byte_wr;
    logic              last_byte;

    assign byte_wr   = (state_reg == COLLECT) && bus.rx_ready;
    assign last_byte = (byte_cnt_reg == CNT_W'(NUM_BYTES - 1));

    // Per-byte staging mux; the byte being written this cycle is visible in stage_next.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_stage
            assign stage_next[8*gi +: 8] = (byte_wr && byte_cnt_reg == CNT_W'(gi))
                                         ? bus.rx_data : stage_reg[8*gi +: 8];
        end
    endgenerate

`ifdef RX_TIMEOUT_EN
    logic timeout_expired;
    logic frame_error_reg;

    rx_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.rx_ready || (state_reg != COLLECT)),
        .enable  (state_reg == COLLECT),
        .expired (timeout_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) frame_error_reg <= 1'b0;
        else       frame_error_reg <= frame_error_next;
    end

    assign bus.frame_error = frame_error_reg;
`else
    // Timeout length is meaningless without the watchdog; keep it referenced.
    logic unused_timeout;
    assign unused_timeout  = (TIMEOUT_CYCLES > 0);
    assign bus.frame_error = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        byte_cnt_next    = byte_cnt_reg;
        cmd_stage_next   = cmd_stage_reg;
        cmd_out_next     = cmd_out_reg;
        word_next        = word_reg;
        frame_valid_next = 1'b0;
        frame_error_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.rx_ready) begin
                    cmd_stage_next = bus.rx_data;
                    byte_cnt_next  = '0;
                    state_next     = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.rx_ready) begin
                    byte_cnt_next = byte_cnt_reg + CNT_W'(1);
                    if (last_byte) begin
                        state_next       = IDLE;
                        cmd_out_next     = cmd_stage_reg;
                        word_next        = stage_next;
                        frame_valid_next = 1'b1;
                    end
                end
`ifdef RX_TIMEOUT_EN
                else if (timeout_expired) begin
                    state_next       = IDLE;
                    frame_error_next = 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            byte_cnt_reg    <= '0;
            cmd_stage_reg   <= '0;
            stage_reg       <= '0;
            cmd_out_reg     <= '0;
            word_reg        <= '0;
            frame_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            byte_cnt_reg    <= byte_cnt_next;
            cmd_stage_reg   <= cmd_stage_next;
            stage_reg       <= stage_next;
            cmd_out_reg     <= cmd_out_next;
            word_reg        <= word_next;
            frame_valid_reg <= frame_valid_next;
        end
    end

    assign bus.cmd_out     = cmd_out_reg;
    assign bus.word_out    = word_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.busy        = (state_reg == COLLECT);
endmodule

// File: tb/tb_rx_frame_assembler.sv
// Randomized + directed bench for rx_frame_assembler (NUM_BYTES=4 and NUM_BYTES=2 instances)
// against a frame-level reference model.
module tb_rx_frame_assembler;
    localparam int TMO = 16;
`ifdef RX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rx_frame_assembler_if #(.NUM_BYTES(4)) bus4 ();
    rx_frame_assembler_if #(.NUM_BYTES(2)) bus2 ();

    rx_frame_assembler #(.NUM_BYTES(4), .TIMEOUT_CYCLES(TMO)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));
    rx_frame_assembler #(.NUM_BYTES(2), .TIMEOUT_CYCLES(TMO)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes since the last frame boundary, per instance.
    int          nb [2] = '{4, 2};
    logic [7:0]  fb [2][5];
    int          fcnt [2];
    int          idle [2];
    logic [7:0]  exp_cmd [2];
    logic [31:0] exp_word [2];
    logic        exp_valid [2];
    logic        exp_err [2];
    int          err_seen [2];
    int          valid_seen [2];

    task automatic model_step(input int i, input logic rst, input logic rdy, input logic [7:0] d);
        logic [31:0] w;
        if (rst) begin
            fcnt[i] = 0; idle[i] = 0; exp_cmd[i] = 8'h00; exp_word[i] = 32'h0;
            exp_valid[i] = 1'b0; exp_err[i] = 1'b0;
        end else begin
            exp_valid[i] = 1'b0;
            exp_err[i]   = 1'b0;
            if (rdy) begin
                fb[i][fcnt[i]] = d;
                fcnt[i]++;
                idle[i] = 0;
                if (fcnt[i] == nb[i] + 1) begin
                    w = 32'h0;
                    for (int k = 0; k < nb[i]; k++) w = w | ({24'h0, fb[i][k+1]} << (8 * k));
                    exp_cmd[i]   = fb[i][0];
                    exp_word[i]  = w;
                    exp_valid[i] = 1'b1;
                    fcnt[i]      = 0;
                end
            end else if (TMO_EN && fcnt[i] > 0) begin
                idle[i]++;
                if (idle[i] == TMO) begin
                    fcnt[i] = 0; idle[i] = 0; exp_err[i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            err_seen[i] = 0; valid_seen[i] = 0;
            model_step(i, 1'b1, 1'b0, 8'h00);
        end
        forever begin
            @(posedge clk);
            model_step(0, reset, bus4.rx_ready, bus4.rx_data);
            model_step(1, reset, bus2.rx_ready, bus2.rx_data);
            #1;
            check("v4_valid", {31'h0, bus4.frame_valid}, {31'h0, exp_valid[0]});
            check("v4_busy",  {31'h0, bus4.busy},        {31'h0, fcnt[0] > 0});
            check("v4_err",   {31'h0, bus4.frame_error}, {31'h0, exp_err[0]});
            check("v4_cmd",   {24'h0, bus4.cmd_out},     {24'h0, exp_cmd[0]});
            check("v4_word",  bus4.word_out,             exp_word[0]);
            check("v2_valid", {31'h0, bus2.frame_valid}, {31'h0, exp_valid[1]});
            check("v2_busy",  {31'h0, bus2.busy},        {31'h0, fcnt[1] > 0});
            check("v2_err",   {31'h0, bus2.frame_error}, {31'h0, exp_err[1]});
            check("v2_cmd",   {24'h0, bus2.cmd_out},     {24'h0, exp_cmd[1]});
            check("v2_word",  {16'h0, bus2.word_out},    exp_word[1]);
            if (bus4.frame_valid) begin
                valid_seen[0]++;
                $display("frame nb=4 cmd=%02h word=%08h", bus4.cmd_out, bus4.word_out);
            end
            if (bus2.frame_valid) begin
                valid_seen[1]++;
                $display("frame nb=2 cmd=%02h word=%04h", bus2.cmd_out, bus2.word_out);
            end
            if (bus4.frame_error) begin
                err_seen[0]++;
                $display("timeout nb=4 abort");
            end
            if (bus2.frame_error) err_seen[1]++;
        end
    end

    task automatic drv(input int i, input logic r, input logic [7:0] d);
        @(negedge clk);
        if (i == 0) begin bus4.rx_ready = r; bus4.rx_data = d; end
        else        begin bus2.rx_ready = r; bus2.rx_data = d; end
    endtask

    task automatic send(input int i, input logic [7:0] b, input int gap);
        drv(i, 1'b1, b);
        repeat (gap) drv(i, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    int v0;
    logic [7:0] frame_b2b [10] = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h02, 8'h04, 8'h03, 8'h02, 8'h01};

    initial begin
        bus4.rx_ready = 1'b0; bus4.rx_data = 8'h00;
        bus2.rx_ready = 1'b0; bus2.rx_data = 8'h00;
        do_reset();
        check("rst_cmd",  {24'h0, bus4.cmd_out}, 32'h0);
        check("rst_word", bus4.word_out, 32'h0);
        check("rst_busy", {31'h0, bus4.busy}, 32'h0);

        // Spaced single frame.
        send(0, 8'h01, 2); send(0, 8'h78, 2); send(0, 8'h56, 2); send(0, 8'h34, 2); send(0, 8'h12, 2);
        check("f1_cmd",  {24'h0, bus4.cmd_out}, 32'h01);
        check("f1_word", bus4.word_out, 32'h12345678);
        check("f1_cnt",  valid_seen[0], 1);

        // Two frames on consecutive-cycle strobes.
        v0 = valid_seen[0];
        for (int k = 0; k < 10; k++) drv(0, 1'b1, frame_b2b[k]);
        drv(0, 1'b0, 8'h00); drv(0, 1'b0, 8'h00);
        check("b2b_cnt",  valid_seen[0] - v0, 2);
        check("b2b_cmd",  {24'h0, bus4.cmd_out}, 32'h02);
        check("b2b_word", bus4.word_out, 32'h01020304);

        // Reset mid-frame, then a fresh frame.
        send(0, 8'h03, 1); send(0, 8'h11, 1); send(0, 8'h22, 1);
        do_reset();
        check("mid_rst_word", bus4.word_out, 32'h0);
        check("mid_rst_busy", {31'h0, bus4.busy}, 32'h0);
        send(0, 8'h04, 1); send(0, 8'hFF, 1); send(0, 8'h00, 1); send(0, 8'h00, 1); send(0, 8'h00, 1);
        check("f3_cmd",  {24'h0, bus4.cmd_out}, 32'h04);
        check("f3_word", bus4.word_out, 32'h000000FF);

        // Long stall mid-frame (aborts only when the watchdog is built).
        send(0, 8'h07, 1); send(0, 8'h44, 1);
        repeat (1000) drv(0, 1'b0, 8'h00);
        send(0, 8'h33, 1); send(0, 8'h22, 1); send(0, 8'h11, 1);
`ifndef RX_TIMEOUT_EN
        check("stall_cmd",  {24'h0, bus4.cmd_out}, 32'h07);
        check("stall_word", bus4.word_out, 32'h11223344);
`else
        // Leftover bytes started a partial frame; let it time out.
        repeat (TMO + 2) drv(0, 1'b0, 8'h00);
        v0 = err_seen[0];
        send(0, 8'h05, 1); send(0, 8'hAA, 0);
        repeat (TMO + 2) drv(0, 1'b0, 8'h00);
        check("tmo_err",  err_seen[0] - v0, 1);
        check("tmo_busy", {31'h0, bus4.busy}, 32'h0);
        check("tmo_cmd",  {24'h0, bus4.cmd_out}, 32'h04);
        check("tmo_word", bus4.word_out, 32'h000000FF);
        send(0, 8'h09, 1); send(0, 8'h0D, 1); send(0, 8'h0C, 1); send(0, 8'h0B, 1); send(0, 8'h0A, 1);
        check("post_tmo_word", bus4.word_out, 32'h0A0B0C0D);
`endif

        // Two-operand-byte instance.
        send(1, 8'h06, 1); send(1, 8'h34, 1); send(1, 8'h12, 1);
        check("nb2_cmd",  {24'h0, bus2.cmd_out}, 32'h06);
        check("nb2_word", {16'h0, bus2.word_out}, 32'h00001234);

        // Randomized traffic on both instances; the model checks every cycle.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else if ($urandom_range(0, 59) == 0) repeat (TMO + 3) drv(n % 2, 1'b0, 8'h00);
            else drv(n % 2, ($urandom_range(0, 2) != 0), 8'($urandom));
            if (n % 2 == 0) begin bus2.rx_ready = 1'b0; end
            else begin bus4.rx_ready = 1'b0; end
        end
        drv(0, 1'b0, 8'h00); drv(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
